hub_linear_seq: RTL and testbench

- Self-sequencing folded linear (fully-connected) layer for the uBrain stochastic/HUB datapath.
- Computes ODIM signed dot products over IDIM inputs, and time-multiplexes them over FOLD output groups and CYC input segments.
- An internal FSM replaces the external load/sel/clear/part control of the previous fold wrappers.
- Adds a start/busy/done handshake, abort, runtime ReLU enable, arithmetic output scaling and saturation.

---
 rtl/hub_linear_seq.sv | 160 ++++++++++++++++
 tb/tb_hub_linear_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub_linear_seq.sv
// Self-sequencing folded fully-connected layer: OPF signed dot products per output group,
// accumulated over CYC input segments, then shifted, ReLU'd, saturated and written to oFmap.
module hub_linear_seq #(
  parameter int IDIM = 110,
  parameter int IWID = 10,
  parameter int ODIM = 256,
  parameter int OWID = IWID,
  parameter int SDIM = 32,
  parameter int FOLD = 4,
  parameter int SHFT = 0,
  localparam int PWID = (FOLD > 1) ? $clog2(FOLD) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      relu_en,
  input  logic [IWID*IDIM-1:0]      iFmap,
  input  logic [IWID*ODIM*IDIM-1:0] iWeig,
  output logic                      busy,
  output logic                      done,
  output logic [PWID-1:0]           part,
  output logic [OWID*ODIM-1:0]      oFmap
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_RUN  | accumulating one input segment per cycle for the current group
  // S_WB   | writing the current group to oFmap, clearing accumulators
  // S_DONE | one-cycle done pulse

  localparam int OPF  = ODIM / FOLD;
  localparam int CYC  = (IDIM + SDIM - 1) / SDIM;
  localparam int AWID = 2*IWID + $clog2(IDIM) + 1;
  localparam int SWID = (CYC > 1) ? $clog2(CYC) : 1;
  localparam int SEGW = SDIM * IWID;
  localparam int PADW = CYC * SEGW;
  localparam int ROWW = IDIM * IWID;
  localparam int GRPW = OPF * ROWW;
  localparam longint OMAX = (longint'(1) <<< (OWID-1)) - 1;
  localparam longint OMIN = -(longint'(1) <<< (OWID-1));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB, S_DONE} state_t;

  state_t                r_state, w_nstate;
  logic [SWID-1:0]       r_seg;
  logic [PWID-1:0]       r_part;
  logic [IWID*IDIM-1:0]  r_x;
  logic                  r_relu;
  logic                  w_clr, w_acc_en, w_wr;
  logic [SEGW-1:0]       w_xseg;
  logic [GRPW-1:0]       w_wgrp;
  logic [OWID-1:0]       w_post [OPF];

  function automatic logic [OWID-1:0] f_post(input logic signed [AWID-1:0] a, input logic relu);
    logic signed [AWID-1:0] v;
    v = a >>> SHFT;
    if (relu && v[AWID-1]) v = '0;
    if (longint'(v) > OMAX) return OWID'(OMAX);
    if (longint'(v) < OMIN) return OWID'(OMIN);
    return OWID'(v);
  endfunction

  // Zero-padding x past IDIM makes the tail terms of the last segment vanish.
  assign w_xseg = SEGW'(PADW'(r_x) >> (int'(r_seg) * SEGW));
  assign w_wgrp = GRPW'(iWeig >> (int'(r_part) * GRPW));

  always_comb begin
    w_nstate = r_state;
    w_clr    = 1'b0;
    w_acc_en = 1'b0;
    w_wr     = 1'b0;
    case (r_state)
      S_IDLE: if (start && !abort) begin
        w_nstate = S_RUN;
        w_clr    = 1'b1;
      end
      S_RUN: if (abort) begin
        w_nstate = S_IDLE;
        w_clr    = 1'b1;
      end else begin
        w_acc_en = 1'b1;
        if (r_seg == SWID'(CYC-1)) w_nstate = S_WB;
      end
      S_WB: begin
        w_clr = 1'b1;
        if (abort) w_nstate = S_IDLE;
        else begin
          w_wr     = 1'b1;
          w_nstate = (r_part == PWID'(FOLD-1)) ? S_DONE : S_RUN;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_seg   <= '0;
      r_part  <= '0;
      r_x     <= '0;
      r_relu  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_seg   <= (r_state == S_RUN && w_nstate == S_RUN) ? r_seg + SWID'(1) : '0;
      if (w_nstate == S_IDLE) r_part <= '0;
      else if (r_state == S_WB && w_nstate == S_RUN) r_part <= r_part + PWID'(1);
      if (r_state == S_IDLE && w_nstate == S_RUN) begin
        r_x    <= iFmap;
        r_relu <= relu_en;
      end
    end
  end

  for (genvar j = 0; j < OPF; j++) begin : g_dot
    logic [SEGW-1:0]        w_wseg;
    logic signed [AWID-1:0] w_sum;
    logic signed [AWID-1:0] r_acc;

    assign w_wseg = SEGW'(PADW'(w_wgrp[j*ROWW +: ROWW]) >> (int'(r_seg) * SEGW));

    always_comb begin
      logic signed [IWID-1:0]   v_a, v_b;
      logic signed [2*IWID-1:0] v_p;
      v_a   = '0;
      v_b   = '0;
      v_p   = '0;
      w_sum = '0;
      for (int k = 0; k < SDIM; k++) begin
        v_a   = w_xseg[k*IWID +: IWID];
        v_b   = w_wseg[k*IWID +: IWID];
        v_p   = v_a * v_b;
        w_sum = w_sum + AWID'(v_p);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_acc <= '0;
      else if (w_clr)    r_acc <= '0;
      else if (w_acc_en) r_acc <= r_acc + w_sum;
    end

    assign w_post[j] = f_post(r_acc, r_relu);
  end

  for (genvar i = 0; i < ODIM; i++) begin : g_out
    logic [OWID-1:0] r_o;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_o <= '0;
      else if (w_wr && r_part == PWID'(i / OPF)) r_o <= w_post[i % OPF];
    end
    assign oFmap[i*OWID +: OWID] = r_o;
  end

  assign busy = (r_state == S_RUN) || (r_state == S_WB);
  assign done = (r_state == S_DONE);
  assign part = r_part;

endmodule

// File: tb/tb_hub_linear_seq.sv
// Scoreboard bench for hub_linear_seq: three configurations share one stimulus set,
// expected outputs come from a plain unsegmented dot-product model.
module tb_hub_linear_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_s, abort_s, relu_s;
  logic [127:0] fmap_s, weig_s;
  int           sel;
  int           n_chk = 0;
  int           n_err = 0;
  int           sb_q[$];

  // per-config parameters, indexed by sel
  int c_idim[3] = '{4, 5, 4};
  int c_odim[3] = '{4, 4, 2};
  int c_owid[3] = '{8, 4, 8};
  int c_shft[3] = '{0, 0, 1};
  int c_fold[3] = '{2, 2, 1};
  int c_cyc[3]  = '{2, 3, 1};

  logic       a_busy, a_done, b_busy, b_done, c_busy, c_done;
  logic [0:0] a_part, b_part, c_part;
  logic [31:0] a_of;
  logic [15:0] b_of, c_of;

  hub_linear_seq #(.IDIM(4), .IWID(4), .ODIM(4), .OWID(8), .SDIM(2), .FOLD(2), .SHFT(0)) u_a (
    .clk(clk), .rst(rst), .start(start_s && sel == 0), .abort(abort_s && sel == 0),
    .relu_en(relu_s), .iFmap(fmap_s[15:0]), .iWeig(weig_s[63:0]),
    .busy(a_busy), .done(a_done), .part(a_part), .oFmap(a_of));

  hub_linear_seq #(.IDIM(5), .IWID(4), .ODIM(4), .OWID(4), .SDIM(2), .FOLD(2), .SHFT(0)) u_b (
    .clk(clk), .rst(rst), .start(start_s && sel == 1), .abort(abort_s && sel == 1),
    .relu_en(relu_s), .iFmap(fmap_s[19:0]), .iWeig(weig_s[79:0]),
    .busy(b_busy), .done(b_done), .part(b_part), .oFmap(b_of));

  hub_linear_seq #(.IDIM(4), .IWID(4), .ODIM(2), .OWID(8), .SDIM(4), .FOLD(1), .SHFT(1)) u_c (
    .clk(clk), .rst(rst), .start(start_s && sel == 2), .abort(abort_s && sel == 2),
    .relu_en(relu_s), .iFmap(fmap_s[15:0]), .iWeig(weig_s[31:0]),
    .busy(c_busy), .done(c_done), .part(c_part), .oFmap(c_of));

  logic         busy_m, done_m, part_m;
  logic [127:0] of_m;
  always_comb begin
    busy_m = a_busy; done_m = a_done; part_m = a_part[0]; of_m = 128'(a_of);
    if (sel == 1) begin
      busy_m = b_busy; done_m = b_done; part_m = b_part[0]; of_m = 128'(b_of);
    end else if (sel == 2) begin
      busy_m = c_busy; done_m = c_done; part_m = c_part[0]; of_m = 128'(c_of);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d (cfg %0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic logic [127:0] f_pack(input int v[$]);
    logic [127:0] r;
    int t;
    r = '0;
    for (int i = 0; i < v.size(); i++) begin
      t = v[i];
      r[i*4 +: 4] = t[3:0];
    end
    return r;
  endfunction

  function automatic int f_sx(input logic [127:0] v, input int idx, input int w);
    int r;
    r = 0;
    for (int b = 0; b < w; b++) if (v[idx*w + b]) r = r | (1 << b);
    if (r >= (1 << (w-1))) r = r - (1 << w);
    return r;
  endfunction

  function automatic int f_ref(input int xv[$], input int wv[$], input int o, input bit relu);
    longint acc, hi, lo;
    acc = 0;
    for (int i = 0; i < c_idim[sel]; i++) acc += longint'(xv[i]) * wv[o*c_idim[sel] + i];
    acc = acc >>> c_shft[sel];
    if (relu && acc < 0) acc = 0;
    hi = (longint'(1) << (c_owid[sel]-1)) - 1;
    lo = -(longint'(1) << (c_owid[sel]-1));
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    return int'(acc);
  endfunction

  // start is sampled at the posedge this task waits on (edge 0)
  task automatic launch(input int xv[$], input int wv[$], input bit relu);
    @(negedge clk);
    fmap_s = f_pack(xv);
    weig_s = f_pack(wv);
    relu_s = relu;
    for (int o = 0; o < c_odim[sel]; o++) sb_q.push_back(f_ref(xv, wv, o, relu));
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    relu_s = ~relu;
    fmap_s = ~fmap_s;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    bit seen;
    lat  = c_fold[sel] * (c_cyc[sel] + 1) + 1;
    seen = 0;
    for (int k = 1; k <= lat + 5 && !seen; k++) begin
      @(negedge clk);
      if (done_m) begin
        chk({tag, "_lat"}, k, lat);
        seen = 1;
      end else if (k < lat) begin
        chk({tag, "_busy"}, int'(busy_m), 1);
        chk({tag, "_part"}, int'(part_m), (k-1) / (c_cyc[sel] + 1));
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_busy_at_done"}, int'(busy_m), 0);
    @(negedge clk);
    chk({tag, "_done_once"}, int'(done_m), 0);
    chk({tag, "_idle_busy"}, int'(busy_m), 0);
    for (int o = 0; o < c_odim[sel]; o++) begin
      if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
      else chk({tag, "_out"}, f_sx(of_m, o, c_owid[sel]), sb_q.pop_front());
    end
  endtask

  initial begin
    int xv[$], wv[$];
    bit d;
    rst = 1'b1; start_s = 1'b0; abort_s = 1'b0; relu_s = 1'b0;
    fmap_s = '0; weig_s = '0; sel = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_busy", int'(busy_m), 0);
      chk("rst_done", int'(done_m), 0);
      chk("rst_part", int'(part_m), 0);
      for (int o = 0; o < c_odim[s]; o++) chk("rst_out", f_sx(of_m, o, c_owid[s]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    sel = 0;

    // basic run
    xv = '{1, 2, 3, 4};
    wv.delete(); for (int i = 0; i < 16; i++) wv.push_back(1);
    launch(xv, wv, 1'b0);
    wait_done("basic");

    // start re-pulsed while busy and during DONE is ignored
    launch(xv, wv, 1'b0);
    fork
      wait_done("hs");
      begin
        repeat (2) @(posedge clk);
        #2 start_s = 1'b1;
        @(posedge clk);
        #2 start_s = 1'b0;
        repeat (3) @(posedge clk);
        #2 start_s = 1'b1;
        @(posedge clk);
        #2 start_s = 1'b0;
      end
    join

    // abort in the WB cycle of group 0
    wv.delete(); for (int i = 0; i < 16; i++) wv.push_back(2);
    launch(xv, wv, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 abort_s = 1'b1;
    @(posedge clk);
    #1 abort_s = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("abort_busy", int'(busy_m), 0);
    chk("abort_part", int'(part_m), 0);
    d = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_m) d = 1;
    end
    chk("abort_nodone", int'(d), 0);
    for (int o = 0; o < 4; o++) chk("abort_keep", f_sx(of_m, o, 8), 10);

    // abort together with start in IDLE
    @(negedge clk);
    start_s = 1'b1; abort_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0; abort_s = 1'b0;
    @(negedge clk);
    chk("abort_start_idle", int'(busy_m), 0);

    launch(xv, wv, 1'b0);
    wait_done("post_abort");

    // random signed runs, alternating relu
    for (int r = 0; r < 4; r++) begin
      xv.delete(); wv.delete();
      for (int i = 0; i < 4; i++) xv.push_back(int'($urandom_range(15)) - 8);
      for (int i = 0; i < 16; i++) wv.push_back(int'($urandom_range(15)) - 8);
      launch(xv, wv, r[0]);
      wait_done("rand");
    end

    // reset mid-RUN
    launch(xv, wv, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy_m), 0);
    chk("midrst_done", int'(done_m), 0);
    for (int o = 0; o < 4; o++) chk("midrst_out", f_sx(of_m, o, 8), 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // tail padding and saturation / relu
    sel = 1;
    xv = '{1, 1, 1, 1, 1};
    wv.delete(); for (int i = 0; i < 20; i++) wv.push_back(1);
    launch(xv, wv, 1'b0);
    wait_done("tail");
    xv = '{7, 7, 7, 7, 7};
    wv.delete(); for (int i = 0; i < 20; i++) wv.push_back(7);
    launch(xv, wv, 1'b0);
    wait_done("sat_pos");
    wv.delete(); for (int i = 0; i < 20; i++) wv.push_back(-7);
    launch(xv, wv, 1'b0);
    wait_done("sat_neg");
    launch(xv, wv, 1'b1);
    wait_done("relu");

    // FOLD=1, CYC=1, arithmetic shift
    sel = 2;
    xv = '{1, 1, 1, 0};
    wv = '{-1, -1, -1, 0, 1, 2, 2, 0};
    launch(xv, wv, 1'b0);
    wait_done("shift");
    for (int o = 0; o < 2; o++) chk("shift_val", f_sx(of_m, o, 8), (o == 0) ? -2 : 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
